// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between two byte producers, the arbiter and the UART TX FIFO.
// The master side is the producers plus the FIFO; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned B = 8
);
  logic         req0_valid;
  logic [B-1:0] req0_data;
  logic         req0_last;
  logic         req0_ready;

  logic         req1_valid;
  logic [B-1:0] req1_data;
  logic         req1_last;
  logic         req1_ready;

  logic         full;
  logic         wr;
  logic [B-1:0] wr_data;

  modport master (
    output req0_valid, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_last,
    input  req1_ready,
    output full,
    input  wr, wr_data
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_last,
    output req1_ready,
    input  full,
    output wr, wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX FIFO write port between
// the RX echo path (requester 0) and the status/message generator (requester 1).
module fifo_wr_arbiter #(
  parameter int unsigned B       = 8,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus,
  output logic [1:0]        grant,
  output logic              len_err
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        state;
  logic          prio;
  logic [CW-1:0] cnt;

  logic          sel1;
  logic          locked;
  logic          cur_valid;
  logic          cur_last;
  logic [B-1:0]  cur_data;
  logic          wr_c;
  logic [CW-1:0] cnt_inc;
  logic          eop_c;

  // Mux the locked requester onto the FIFO port; gated by full in the same cycle.
  always_comb begin
    sel1      = (state == LOCK1);
    locked    = (state != IDLE);
    cur_valid = sel1 ? bus.req1_valid : bus.req0_valid;
    cur_last  = sel1 ? bus.req1_last  : bus.req0_last;
    cur_data  = sel1 ? bus.req1_data  : bus.req0_data;
    wr_c      = locked & cur_valid & ~bus.full;
    cnt_inc   = cnt + CW'(1);
    eop_c     = wr_c & (cur_last | (cnt_inc == LIMIT));
  end

  always_comb begin
    bus.req0_ready = (state == LOCK0) & ~bus.full;
    bus.req1_ready = (state == LOCK1) & ~bus.full;
    bus.wr         = wr_c;
    bus.wr_data    = locked ? cur_data : '0;
  end

  // Arbitration, packet lock and beat counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 2'b00;
      prio    <= 1'b0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= eop_c & ~cur_last;
      case (state)
        IDLE: begin
          if (bus.req0_valid && (!bus.req1_valid || !prio)) begin
            state <= LOCK0;
            grant <= 2'b01;
          end else if (bus.req1_valid) begin
            state <= LOCK1;
            grant <= 2'b10;
          end
        end
        LOCK0, LOCK1: begin
          if (eop_c) begin
            state <= IDLE;
            grant <= 2'b00;
            cnt   <= '0;
            prio  <= ~sel1;
          end else if (wr_c) begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Shares the single write port of the UART TX `fifo` (W=4, B=8, 16 entries) between two byte producers:
  - requester 0: the RX echo path;
  - requester 1: the status/message generator.
- Round-robin arbitration with packet lock: once a requester is granted, its multi-byte message enters the FIFO contiguously, never interleaved.
- A beat limit forces release if a requester never signals end of packet.
- Sits between the producers and `fifo.wr`/`fifo.wr_data`, and observes `fifo.full`.

## Interface
Parameters:
- B, 8, data width in bits; must match the FIFO's B.
- MAX_LEN, 16, maximum beats per packet before forced release (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  B  requester 0 byte.
- req0_last  in  1  requester 0 byte is the final byte of its packet.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid, req1_data, req1_last, req1_ready: same as requester 0, for requester 1.
- full  in  1  `fifo.full`.
- wr  out  1  drives `fifo.wr`.
- wr_data  out  B  drives `fifo.wr_data`.
- grant  out  2  one-hot registered grant: bit0 = req0, bit1 = req1, 00 = idle.
- len_err  out  1  registered one-cycle pulse when a packet is cut at MAX_LEN.

## Operation
State machine: IDLE, LOCK0, LOCK1. Registered state:
- prio: 0 = requester 0 preferred.
- cnt: beat counter, 8 bits.

IDLE:
- grant=00; both ready=0; wr=0; wr_data=0.
- Only req0_valid: go to LOCK0. Only req1_valid: go to LOCK1.
- Both valid: go to LOCK<prio>.
- Neither valid: stay in IDLE.

LOCKx:
- grant = one-hot x.
- reqx_ready = !full; the other requester's ready = 0.
- wr = reqx_valid & !full; wr_data = reqx_data (combinational mux).
- Each accepted beat (wr=1) increments cnt.
- End of packet: an accepted beat with reqx_last=1, or the accepted beat that makes cnt equal MAX_LEN. On that edge:
  - return to IDLE;
  - cnt clears to 0;
  - prio becomes the other requester.
- If that final beat has reqx_last=0, len_err pulses high for the following cycle.
- If both conditions hold on the same beat, len_err stays 0.
- reqx_valid deasserting mid-packet does not release the lock: grant holds and cnt holds.
- full=1 while locked: ready=0 and wr=0. The lock holds indefinitely; there is no timeout while stalled.
- The non-granted requester's ready stays 0, and its valid is only sampled in IDLE.

Width rule:
- cnt saturates logically at MAX_LEN, because release occurs there.
- cnt never wraps.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, grant=00, prio=0, cnt=0, len_err=0;
  - wr=0, wr_data=0, req0_ready=0, req1_ready=0, combinationally.
- Reset mid-packet: the lock is abandoned immediately, and no further wr occurs until the next arbitration.
- Arbitration latency: one cycle. valid seen in IDLE at edge N gives grant at N, and the first write can occur in cycle N to N+1.
- Throughput while locked and not full: one byte per cycle.
- Packet turnaround: one IDLE bubble cycle between consecutive packets, including back-to-back packets from the same requester.
- wr follows full in the same cycle, so the arbiter never writes when full=1. The FIFO therefore never sees an overflow write.
- ready and wr are combinational from valid, full and state. grant and len_err are registered.

## Test plan
- Single packet: req0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), req1 idle -> grant=01 one cycle after valid; wr high 3 consecutive cycles with data 41, 42, 43; grant=00 after; prio=1; FIFO holds 3 entries in order.
- Contention: both valid at the same edge after reset, req0 packet 0x10..0x12, req1 packet 0x20..0x21 -> FIFO order 10, 11, 12, 20, 21 with no interleaving; exactly one idle cycle between packets; then a second contention grants req0 again (prio flipped twice).
- Full backpressure: preload FIFO with 15 bytes; req1 sends 3 bytes -> first byte written; full=1 stalls ready=0 and wr=0; after the bench reads 2 bytes, the remaining 2 bytes are written in order; lock is held throughout.
- Length limit: MAX_LEN=4; req0 streams 6 bytes with last never set -> exactly 4 writes; len_err=1 for one cycle; return to IDLE; req0 re-arbitrates and the remaining bytes form a new packet.
- Last on limit: MAX_LEN=4; req0 sends 4 bytes with last on the 4th -> release, len_err stays 0.
- Reset mid-packet: assert rst_n=0 after the 2nd of 5 bytes -> wr=0 and grant=00 immediately; prio=0; after release, both valid -> req0 granted first.
